// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// MMIO word offsets and CAUSE register layout.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } intcState_t;

  // Word offsets inside the 4-word MMIO window (address[3:2])
  localparam logic [1:0] OFF_MASK  = 2'd0;
  localparam logic [1:0] OFF_CAUSE = 2'd1;
  localparam logic [1:0] OFF_ACK   = 2'd2;
  localparam logic [1:0] OFF_STATS = 2'd3;

  localparam int unsigned CAUSE_VALID_BIT = 31;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module intc_prio_enc #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               anyReq
);

  logic found;

  always_comb begin
    id    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !found) begin
        id    = ID_W'(i);
        found = 1'b1;
      end
    end
  end

  assign anyReq = |req;

endmodule

// File: rtl/intc_scheduler.sv
// Memory-mapped interrupt controller: edge capture, mask, fixed priority and
// a three-state CPU handshake. Define INTC_STATS_EN to add the service counter.
module intc_scheduler
  import intc_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned ID_W      = 2,
  parameter logic [31:0] BASE_ADDR = 32'hffff0080
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        data,
  input  logic [31:0]        address,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               InterruptTaken,
  input  logic               Eret,
  output logic               Interrupt,
  output logic [31:0]        rdata,
  output logic               IntcAddress
);

  intcState_t         state, stateNext;
  logic [NUM_SRC-1:0] mask, pending, prevSrc;
  logic [NUM_SRC-1:0] rise, ackClr, req;
  logic [ID_W-1:0]    winId, causeId;
  logic               causeValid;
  logic               anyReq, stillReq;
  logic               causeLoad, causeClr, taken;
  logic               hit, wrMask, wrAck;
  logic [1:0]         wordOff;
  logic [31:0]        maskWord, causeWord, statsWord;
  logic               unusedBits;

  assign hit         = (address[31:4] == BASE_ADDR[31:4]);
  assign IntcAddress = hit;
  assign wordOff     = address[3:2];
  assign wrMask      = MemWrite && hit && (wordOff == OFF_MASK);
  assign wrAck       = MemWrite && hit && (wordOff == OFF_ACK);
  assign unusedBits  = ^{address[1:0], data};

  assign rise = irq_src & ~prevSrc;
  assign req  = pending & mask;

  always_comb begin
    ackClr = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      ackClr[i] = wrAck && (data[ID_W-1:0] == ID_W'(i));
    end
  end

  // A new edge on the same cycle as an ACK keeps the bit set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prevSrc <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      prevSrc <= irq_src;
      pending <= (pending & ~ackClr) | rise;
      if (wrMask) begin
        mask <= data[NUM_SRC-1:0];
      end
    end
  end

  intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req    (req),
    .id     (winId),
    .anyReq (anyReq)
  );

  assign stillReq = |(req & (NUM_SRC'(1) << causeId));

  always_comb begin
    stateNext = state;
    causeLoad = 1'b0;
    causeClr  = 1'b0;
    taken     = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext = ASSERT;
          causeLoad = 1'b1;
        end
      end
      ASSERT: begin
        if (InterruptTaken) begin
          stateNext = SERVICE;
          taken     = 1'b1;
        end else if (!stillReq) begin
          stateNext = IDLE;
          causeClr  = 1'b1;
        end
      end
      SERVICE: begin
        if (Eret) begin
          stateNext = IDLE;
          causeClr  = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        causeClr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      Interrupt <= 1'b0;
    end else begin
      state     <= stateNext;
      Interrupt <= (stateNext == ASSERT);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      causeValid <= 1'b0;
      causeId    <= '0;
    end else if (causeLoad) begin
      causeValid <= 1'b1;
      causeId    <= winId;
    end else if (causeClr) begin
      causeValid <= 1'b0;
      causeId    <= '0;
    end
  end

`ifdef INTC_STATS_EN
  logic        wrStats;
  logic [31:0] statsCnt;

  assign wrStats = MemWrite && hit && (wordOff == OFF_STATS);

  // Clear and count in the same cycle leaves the counter at one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      statsCnt <= '0;
    end else if (wrStats) begin
      statsCnt <= {31'd0, taken};
    end else if (taken) begin
      statsCnt <= statsCnt + 32'd1;
    end
  end

  assign statsWord = statsCnt;
`else
  logic unusedTaken;
  assign unusedTaken = taken;
  assign statsWord   = '0;
`endif

  always_comb begin
    maskWord                   = '0;
    maskWord[NUM_SRC-1:0]      = mask;
    causeWord                  = '0;
    causeWord[CAUSE_VALID_BIT] = causeValid;
    causeWord[ID_W-1:0]        = causeId;
  end

  always_comb begin
    rdata = '0;
    if (MemRead && hit) begin
      case (wordOff)
        OFF_MASK:  rdata = maskWord;
        OFF_CAUSE: rdata = causeWord;
        OFF_STATS: rdata = statsWord;
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intc_scheduler.sv
// Self-checking bench for intc_scheduler: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the controller.
module tb_intc_scheduler;

  localparam logic [31:0] BASE = 32'hffff0080;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_src = '0;
  logic [31:0] data = '0;
  logic [31:0] address = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        InterruptTaken = 1'b0;
  logic        Eret = 1'b0;
  logic        Interrupt;
  logic [31:0] rdata;
  logic        IntcAddress;

  intc_scheduler #(
    .NUM_SRC   (4),
    .ID_W      (2),
    .BASE_ADDR (BASE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .irq_src        (irq_src),
    .data           (data),
    .address        (address),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .InterruptTaken (InterruptTaken),
    .Eret           (Eret),
    .Interrupt      (Interrupt),
    .rdata          (rdata),
    .IntcAddress    (IntcAddress)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nPass   = 0;

  // Behavioural model: mode 0 = quiet, 1 = requesting CPU, 2 = handler running
  bit [3:0]  mPend, mMask, mPrev;
  int        mMode, mId;
  bit        mValid, mInt;
  bit [31:0] mStats;

  task automatic modelReset();
    mPend = '0; mMask = '0; mPrev = '0;
    mMode = 0; mId = 0; mValid = 1'b0; mInt = 1'b0; mStats = '0;
  endtask

  function automatic int lowestSet(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] causeExp();
    logic [31:0] v;
    bit [31:0] idBits;
    idBits = mId;
    v = '0;
    v[31] = mValid;
    v[1:0] = idBits[1:0];
    return v;
  endfunction

  function automatic logic [31:0] statsExp();
`ifdef INTC_STATS_EN
    return mStats;
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    bit [3:0]  req, nPend, nMask;
    bit [31:0] nStats;
    bit        nValid, inWin, takenNow;
    int        w, nMode, nId, off;
    inWin = (address >= BASE) && (address < BASE + 32'd16);
    off = int'((address - BASE) / 4);
    req = mPend & mMask;
    w = lowestSet(req);
    nMode = mMode; nValid = mValid; nId = mId; nStats = mStats;
    nMask = mMask; nPend = mPend; takenNow = 1'b0;
    if (mMode == 0) begin
      if (w >= 0) begin nMode = 1; nValid = 1'b1; nId = w; end
    end else if (mMode == 1) begin
      if (InterruptTaken) begin nMode = 2; nStats = mStats + 32'd1; takenNow = 1'b1; end
      else if (!req[mId]) begin nMode = 0; nValid = 1'b0; nId = 0; end
    end else if (Eret) begin
      nMode = 0; nValid = 1'b0; nId = 0;
    end
    if (MemWrite && inWin) begin
      if (off == 0) nMask = data[3:0];
      if (off == 2) nPend[data[1:0]] = 1'b0;
      if (off == 3) nStats = takenNow ? 32'd1 : 32'd0;
    end
    nPend = nPend | (irq_src & ~mPrev);
    @(posedge clock);
    mPrev = irq_src; mPend = nPend; mMask = nMask; mMode = nMode;
    mValid = nValid; mId = nId; mStats = nStats; mInt = (nMode == 1);
    #1;
    MemWrite = 1'b0; InterruptTaken = 1'b0; Eret = 1'b0;
  endtask

  task automatic readReg(input int idx, output logic [31:0] v);
    address = BASE + 32'(idx * 4);
    MemRead = 1'b1;
    #1;
    v = rdata;
    MemRead = 1'b0;
  endtask

  task automatic writeReg(input int idx, input logic [31:0] val);
    address = BASE + 32'(idx * 4);
    data = val;
    MemWrite = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    @(posedge clock); #1;
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL reset_int: got %b expected 0", Interrupt); else nPass++;
    readReg(0, v);
    nChecks++; if (v !== 32'd0) $display("FAIL reset_mask: got %h expected 0", v); else nPass++;
    readReg(1, v);
    nChecks++; if (v !== 32'd0) $display("FAIL reset_cause: got %h expected 0", v); else nPass++;
    address = 32'hffff008c; #1;
    nChecks++; if (IntcAddress !== 1'b1) $display("FAIL addr_top: got %b expected 1", IntcAddress); else nPass++;
    address = 32'hffff0090; #1;
    nChecks++; if (IntcAddress !== 1'b0) $display("FAIL addr_above: got %b expected 0", IntcAddress); else nPass++;
    address = 32'hffff007c; #1;
    nChecks++; if (IntcAddress !== 1'b0) $display("FAIL addr_below: got %b expected 0", IntcAddress); else nPass++;
    reset = 1'b1;
    modelReset();
  endtask

  task automatic test_masked_pending();
    logic [31:0] v;
    irq_src = 4'b0001; tick();
    irq_src = 4'b0000; tick(); tick(); tick();
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL masked_int: got %b expected 0", Interrupt); else nPass++;
    readReg(1, v);
    nChecks++; if (v !== 32'd0) $display("FAIL masked_cause: got %h expected 0", v); else nPass++;
    writeReg(0, 32'h1);
    tick();
    nChecks++; if (Interrupt !== 1'b1) $display("FAIL held_pending_int: got %b expected 1", Interrupt); else nPass++;
    readReg(1, v);
    nChecks++; if (v !== 32'h80000000) $display("FAIL held_pending_cause: got %h expected 80000000", v); else nPass++;
    writeReg(2, 32'h0);
    nChecks++; if (Interrupt !== 1'b1) $display("FAIL ack_same_cycle_int: got %b expected 1", Interrupt); else nPass++;
    tick();
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL ack_drop_int: got %b expected 0", Interrupt); else nPass++;
    readReg(1, v);
    nChecks++; if (v !== 32'd0) $display("FAIL ack_drop_cause: got %h expected 0", v); else nPass++;
  endtask

  task automatic test_priority();
    logic [31:0] v;
    writeReg(0, 32'hf);
    irq_src = 4'b0110; tick();
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL prio_latency1: got %b expected 0", Interrupt); else nPass++;
    tick();
    nChecks++; if (Interrupt !== 1'b1) $display("FAIL prio_latency2: got %b expected 1", Interrupt); else nPass++;
    readReg(1, v);
    nChecks++; if (v !== 32'h80000001) $display("FAIL prio_cause: got %h expected 80000001", v); else nPass++;
    address = BASE + 32'd4; MemRead = 1'b0; #1;
    nChecks++; if (rdata !== 32'd0) $display("FAIL rdata_unselected: got %h expected 0", rdata); else nPass++;
    InterruptTaken = 1'b1; tick();
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL service_int: got %b expected 0", Interrupt); else nPass++;
    writeReg(2, 32'h1);
    Eret = 1'b1; tick();
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL eret_idle_int: got %b expected 0", Interrupt); else nPass++;
    tick();
    nChecks++; if (Interrupt !== 1'b1) $display("FAIL reassert_int: got %b expected 1", Interrupt); else nPass++;
    readReg(1, v);
    nChecks++; if (v !== 32'h80000002) $display("FAIL reassert_cause: got %h expected 80000002", v); else nPass++;
    InterruptTaken = 1'b1; tick();
    writeReg(2, 32'h2);
    Eret = 1'b1; tick();
    irq_src = 4'b0000; tick(); tick();
    nChecks++; if (Interrupt !== mInt) $display("FAIL prio_cleanup_int: got %b expected %b", Interrupt, mInt); else nPass++;
  endtask

  task automatic test_mask_drop();
    logic [31:0] v;
    irq_src = 4'b1000; tick();
    irq_src = 4'b0000; tick();
    readReg(1, v);
    nChecks++; if (v !== 32'h80000003) $display("FAIL drop_cause_pre: got %h expected 80000003", v); else nPass++;
    writeReg(0, 32'h7);
    nChecks++; if (Interrupt !== 1'b1) $display("FAIL drop_int_pre: got %b expected 1", Interrupt); else nPass++;
    tick();
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL drop_int: got %b expected 0", Interrupt); else nPass++;
    readReg(1, v);
    nChecks++; if (v !== 32'd0) $display("FAIL drop_cause: got %h expected 0", v); else nPass++;
    writeReg(2, 32'h3);
    writeReg(0, 32'hf);
    tick();
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL drop_acked_int: got %b expected 0", Interrupt); else nPass++;
  endtask

  task automatic test_level_hold();
    int   rises;
    logic prevI;
    rises = 0;
    prevI = Interrupt;
    irq_src = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      if (c == 2) InterruptTaken = 1'b1;
      if (c == 3) begin address = BASE + 32'd8; data = 32'd0; MemWrite = 1'b1; end
      if (c == 4) Eret = 1'b1;
      tick();
      nChecks++; if (Interrupt !== mInt) $display("FAIL hold_int c=%0d: got %b expected %b", c, Interrupt, mInt); else nPass++;
      if (Interrupt === 1'b1 && prevI === 1'b0) rises++;
      prevI = Interrupt;
    end
    nChecks++; if (rises !== 1) $display("FAIL hold_rises: got %0d expected 1", rises); else nPass++;
    irq_src = 4'b0000; tick();
  endtask

  task automatic test_stats();
    logic [31:0] v;
    writeReg(1, 32'hffffffff);
    readReg(1, v);
    nChecks++; if (v !== 32'd0) $display("FAIL cause_readonly: got %h expected 0", v); else nPass++;
`ifdef INTC_STATS_EN
    writeReg(3, 32'd0);
    for (int k = 0; k < 3; k++) begin
      irq_src = 4'b0100; tick();
      irq_src = 4'b0000; tick();
      InterruptTaken = 1'b1; tick();
      writeReg(2, 32'h2);
      Eret = 1'b1; tick();
    end
    readReg(3, v);
    nChecks++; if (v !== 32'd3) $display("FAIL stats_three: got %h expected 3", v); else nPass++;
    writeReg(3, 32'd0);
    readReg(3, v);
    nChecks++; if (v !== 32'd0) $display("FAIL stats_clear: got %h expected 0", v); else nPass++;
    irq_src = 4'b0100; tick();
    irq_src = 4'b0000; tick();
    address = BASE + 32'd12; MemWrite = 1'b1; InterruptTaken = 1'b1; tick();
    readReg(3, v);
    nChecks++; if (v !== 32'd1) $display("FAIL stats_clear_and_count: got %h expected 1", v); else nPass++;
    writeReg(2, 32'h2);
    Eret = 1'b1; tick();
`else
    writeReg(3, 32'h1234);
    readReg(3, v);
    nChecks++; if (v !== 32'd0) $display("FAIL stats_absent: got %h expected 0", v); else nPass++;
`endif
    readReg(2, v);
    nChecks++; if (v !== 32'd0) $display("FAIL ack_reads_zero: got %h expected 0", v); else nPass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    writeReg(0, 32'hf);
    irq_src = 4'b0010; tick();
    irq_src = 4'b0000; tick();
    nChecks++; if (Interrupt !== 1'b1) $display("FAIL pre_reset_int: got %b expected 1", Interrupt); else nPass++;
    #2;
    reset = 1'b0;
    #1;
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL async_reset_int: got %b expected 0", Interrupt); else nPass++;
    readReg(0, v);
    nChecks++; if (v !== 32'd0) $display("FAIL async_reset_mask: got %h expected 0", v); else nPass++;
    readReg(1, v);
    nChecks++; if (v !== 32'd0) $display("FAIL async_reset_cause: got %h expected 0", v); else nPass++;
    modelReset();
    @(posedge clock); #1;
    reset = 1'b1;
    tick();
    nChecks++; if (Interrupt !== 1'b0) $display("FAIL post_reset_int: got %b expected 0", Interrupt); else nPass++;
  endtask

  task automatic test_random();
    logic [31:0] v;
    int sel;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) irq_src[b] = ~irq_src[b];
      if ($urandom_range(3) == 0) begin
        sel = $urandom_range(5);
        if (sel == 4) address = BASE + 32'd16;
        else if (sel == 5) address = BASE - 32'd4;
        else address = BASE + 32'(sel * 4);
        data = $urandom;
        MemWrite = 1'b1;
      end
      InterruptTaken = ($urandom_range(2) == 0);
      Eret = ($urandom_range(3) == 0);
      tick();
      nChecks++; if (Interrupt !== mInt) $display("FAIL rand_int n=%0d: got %b expected %b", n, Interrupt, mInt); else nPass++;
      readReg(1, v);
      nChecks++; if (v !== causeExp()) $display("FAIL rand_cause n=%0d: got %h expected %h", n, v, causeExp()); else nPass++;
      readReg(0, v);
      nChecks++; if (v !== {28'd0, mMask}) $display("FAIL rand_mask n=%0d: got %h expected %h", n, v, {28'd0, mMask}); else nPass++;
      readReg(3, v);
      nChecks++; if (v !== statsExp()) $display("FAIL rand_stats n=%0d: got %h expected %h", n, v, statsExp()); else nPass++;
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_masked_pending();
    test_priority();
    test_mask_drop();
    test_level_hold();
    test_stats();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", nChecks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/intc_scheduler.md
Name: intc_scheduler

Overview:
Memory-mapped interrupt controller that sits between the timer, other interrupt sources and the CPU pipeline. It latches source edges, applies a software mask, and picks one winner by fixed priority. It presents a single Interrupt line to the CPU and sequences acknowledge and return through a three-state handshake. The timer's TimerInterrupt drives source 0; the MMIO decode shares the data/address/MemRead/MemWrite bus used by the timer.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..32)
ID_W, 2, width of source id; must be >= clog2(NUM_SRC)
BASE_ADDR, 32'hffff0080, base of the 4-word MMIO window

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
irq_src  input  NUM_SRC  level interrupt lines; bit 0 = timer
data  input  32  CPU store data
address  input  32  CPU data address
MemRead  input  1  CPU load strobe
MemWrite  input  1  CPU store strobe
InterruptTaken  input  1  one-cycle pulse: CPU has vectored to the handler
Eret  input  1  one-cycle pulse: handler returning
Interrupt  output  1  registered interrupt request to CPU
rdata  output  32  MMIO read data; 0 when not selected
IntcAddress  output  1  high when address is inside the window (combinational)

Behaviour:
- MMIO map (word offsets from BASE_ADDR):
  - +0x0 MASK (R/W, NUM_SRC bits)
  - +0x4 CAUSE (R: bit31 = valid, [ID_W-1:0] = id)
  - +0x8 ACK (W: data[ID_W-1:0] = id to clear)
  - +0xC STATS (see optional feature)
- Reads are combinational: rdata = selected register when MemRead && hit, else 0.
- Reset values: MASK = 0, pending = 0, prev_src = 0, CAUSE = 0 (valid = 0), state = IDLE, Interrupt = 0.
- Edge detect: prev_src <= irq_src every cycle. pending[i] sets on irq_src[i] & ~prev_src[i].
  - Level-held lines such as the timer do not re-trigger.
- ACK write clears pending[id]. If a set and a clear hit the same bit in the same cycle, set wins.
- Arbiter: winner = lowest index i with pending[i] & MASK[i]; any_req = OR of (pending & MASK).
- FSM:
  - IDLE: Interrupt = 0. If any_req, latch CAUSE = {1, winner} and go to ASSERT.
  - ASSERT: Interrupt = 1.
    - If InterruptTaken, go to SERVICE.
    - Else if CAUSE.id is no longer pending&MASK (masked or acked), clear valid and go to IDLE.
  - SERVICE: Interrupt = 0. New requests only accumulate in pending. On Eret, clear valid and go to IDLE.
  - Eret in IDLE or ASSERT is ignored.
- Latency: a source rising before clock edge k sets pending at k; the FSM enters ASSERT at k+1, so Interrupt is high after edge k+1. Two cycles from line to Interrupt.
- Eret without an ACK leaves pending set, so the same id re-asserts one cycle after returning to IDLE.
- Writes outside the window, or to read-only offsets, have no effect.
- Reset asserted mid-operation returns every state and register to its reset value immediately; Interrupt drops asynchronously.

Optional Feature:
- Macro: INTC_STATS_EN.
- Defined: a 32-bit counter increments on each ASSERT->SERVICE transition, wraps 0xffffffff->0, and is readable at +0xC. A write to +0xC clears it; if a write and a transition occur in the same cycle, the counter ends at 1.
- Undefined: no counter is instantiated, +0xC reads 0 and writes are ignored.

Decomposition:
- Package intc_pkg holds:
  - state encoding IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2
  - offsets OFF_MASK, OFF_CAUSE, OFF_ACK, OFF_STATS
  - CAUSE_VALID_BIT = 31
- One sub-module, intc_prio_enc: parameterised fixed-priority encoder (pending&MASK -> winner id, any_req).
- Registers use the existing register/dffe cells with an explicit reset value.

Test Plan:
- Reset, then pulse irq_src[0] with MASK = 0 -> Interrupt stays 0; CAUSE reads 0; pending[0] stays set.
- Write MASK = 0xF; raise irq_src[2] and irq_src[1] in the same cycle -> Interrupt high 2 cycles later; CAUSE reads 0x80000001.
- From that point: InterruptTaken pulse, write ACK = 1, Eret -> IDLE; then re-asserts with CAUSE = 0x80000002.
- In ASSERT with id 3, write MASK = 0x7 -> Interrupt drops next cycle; CAUSE reads 0.
- Hold irq_src[0] high for 10 cycles, then service and ACK id 0 -> exactly one interrupt, no re-trigger.
- Drive reset low while in SERVICE -> Interrupt = 0, MASK = 0, CAUSE = 0 without waiting for a clock edge.
- With INTC_STATS_EN, service 3 interrupts -> +0xC reads 3; write +0xC -> reads 0.
